// File: rtl/led_pwm_ctrl_pkg.sv
// Shared definitions for the LED PWM controller: register offsets,
// CTRL bit positions, BLINK field positions and the CTRL register type.
// The BLINK register is present only when LED_PWM_CTRL_BLINK_EN is defined.
package led_pwm_ctrl_pkg;

    // Byte offsets within the block's window (addr_i[7:2] is the word index)
    localparam logic [7:0] OFF_CTRL      = 8'h00;
    localparam logic [7:0] OFF_OUT       = 8'h04;
    localparam logic [7:0] OFF_PRESCALE  = 8'h08;
    localparam logic [7:0] OFF_BLINK     = 8'h0C;
    localparam logic [7:0] OFF_DUTY_BASE = 8'h20;

    // CTRL bit indices
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_BIT = 1;

    // BLINK field positions
    localparam int BLINK_MASK_LSB = 0;
    localparam int BLINK_HALF_LSB = 16;
    localparam int BLINK_HALF_W   = 8;

    // Packed so that EN lands on bit 0 and MODE on bit 1 of the readback word
    typedef struct packed {
        logic mode;
        logic en;
    } ctrl_reg_t;

endpackage

// File: rtl/led_pwm_timebase.sv
// PWM timebase: prescaler, PWM step counter and a one-cycle wrap pulse.
// A clear request restarts both counters and wins over a tick in the same
// cycle; while disabled both counters are held at zero.
module led_pwm_timebase #(
    parameter int PwmWidth = 8
) (
    input  logic                clk_sys,
    input  logic                rst_sys_n,
    input  logic                en,
    input  logic                clr,
    input  logic [15:0]         prescale,
    output logic [PwmWidth-1:0] pwm_cnt,
    output logic                pwm_wrap
);

    logic [15:0] pre_q;
    logic        tick;

    // The >= keeps the prescaler from running away if PRESCALE shrinks below it
    assign tick = (pre_q >= prescale);

    // Prescaler and PWM counter advance; wrap pulses alongside the max->0 step
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            pre_q    <= 16'd0;
            pwm_cnt  <= '0;
            pwm_wrap <= 1'b0;
        end else if (!en || clr) begin
            pre_q    <= 16'd0;
            pwm_cnt  <= '0;
            pwm_wrap <= 1'b0;
        end else if (tick) begin
            pre_q    <= 16'd0;
            pwm_cnt  <= pwm_cnt + 1'b1;
            pwm_wrap <= &pwm_cnt;
        end else begin
            pre_q    <= pre_q + 16'd1;
            pwm_wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped LED controller: bus decode, register file, direct/PWM
// output mux and optional blink gating (LED_PWM_CTRL_BLINK_EN).
// Every request is granted in the same cycle and answered one cycle later.
module led_pwm_ctrl
    import led_pwm_ctrl_pkg::*;
#(
    parameter int          NumLeds       = 4,
    parameter int          PwmWidth      = 8,
    parameter logic [15:0] PrescaleReset = 16'd0
) (
    input  logic               clk_sys,
    input  logic               rst_sys_n,
    input  logic               req_i,
    output logic               gnt_o,
    input  logic               we_i,
    input  logic [3:0]         be_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    output logic               rvalid_o,
    output logic [31:0]        rdata_o,
    output logic               err_o,
    output logic [NumLeds-1:0] led_o,
    output logic               pwm_wrap_o
);

    ctrl_reg_t            ctrl_q;
    logic [NumLeds-1:0]   out_q;
    logic [15:0]          prescale_q;
    logic [PwmWidth-1:0]  duty_q [NumLeds];

    logic [7:0]           reg_off;
    logic                 hit;
    logic                 wr_en;
    logic                 sel_ctrl;
    logic                 sel_out;
    logic                 sel_pre;
    logic [NumLeds-1:0]   sel_duty;
    logic [31:0]          rd_word;
    logic [31:0]          wr_word;

    logic [PwmWidth-1:0]  pwm_cnt;
    logic                 pwm_wrap;
    logic [NumLeds-1:0]   pwm_on;
    logic [NumLeds-1:0]   blink_off;
    logic                 unused_addr;

`ifdef LED_PWM_CTRL_BLINK_EN
    logic                 sel_blink;
    logic [NumLeds-1:0]   blink_mask_q;
    logic [7:0]           blink_half_q;
    logic [7:0]           blink_cnt_q;
    logic                 blink_phase_q;
`endif

    assign gnt_o       = req_i;
    assign reg_off     = {addr_i[7:2], 2'b00};
    assign wr_en       = req_i & we_i & hit;
    assign unused_addr = ^{addr_i[31:8], addr_i[1:0]};
    assign pwm_wrap_o  = pwm_wrap;

    // Address decode, readback mux and byte-lane merge of the write data
    always_comb begin
        hit      = 1'b0;
        sel_ctrl = 1'b0;
        sel_out  = 1'b0;
        sel_pre  = 1'b0;
        sel_duty = '0;
        rd_word  = '0;
`ifdef LED_PWM_CTRL_BLINK_EN
        sel_blink = 1'b0;
`endif
        case (reg_off)
            OFF_CTRL: begin
                hit                    = 1'b1;
                sel_ctrl               = 1'b1;
                rd_word[CTRL_EN_BIT]   = ctrl_q.en;
                rd_word[CTRL_MODE_BIT] = ctrl_q.mode;
            end
            OFF_OUT: begin
                hit                  = 1'b1;
                sel_out              = 1'b1;
                rd_word[NumLeds-1:0] = out_q;
            end
            OFF_PRESCALE: begin
                hit           = 1'b1;
                sel_pre       = 1'b1;
                rd_word[15:0] = prescale_q;
            end
`ifdef LED_PWM_CTRL_BLINK_EN
            OFF_BLINK: begin
                hit                                     = 1'b1;
                sel_blink                               = 1'b1;
                rd_word[BLINK_MASK_LSB +: NumLeds]      = blink_mask_q;
                rd_word[BLINK_HALF_LSB +: BLINK_HALF_W] = blink_half_q;
            end
`endif
            default: begin
                for (int i = 0; i < NumLeds; i++) begin
                    if (reg_off == 8'(int'(OFF_DUTY_BASE) + 4 * i)) begin
                        hit                   = 1'b1;
                        sel_duty[i]           = 1'b1;
                        rd_word[PwmWidth-1:0] = duty_q[i];
                    end
                end
            end
        endcase
        wr_word = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) wr_word[8*b +: 8] = wdata_i[8*b +: 8];
        end
    end

    // Bus response: one cycle after each request; reads of unmapped space error out
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= req_i;
            err_o    <= req_i & ~hit;
            rdata_o  <= (req_i && !we_i && hit) ? rd_word : 32'd0;
        end
    end

    // Register file updates; bits beyond each field are dropped
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            ctrl_q     <= '0;
            out_q      <= '0;
            prescale_q <= PrescaleReset;
            for (int i = 0; i < NumLeds; i++) duty_q[i] <= '0;
        end else if (wr_en) begin
            if (sel_ctrl) begin
                ctrl_q.en   <= wr_word[CTRL_EN_BIT];
                ctrl_q.mode <= wr_word[CTRL_MODE_BIT];
            end
            if (sel_out) out_q <= wr_word[NumLeds-1:0];
            if (sel_pre) prescale_q <= wr_word[15:0];
            for (int i = 0; i < NumLeds; i++) begin
                if (sel_duty[i]) duty_q[i] <= wr_word[PwmWidth-1:0];
            end
        end
    end

    led_pwm_timebase #(
        .PwmWidth (PwmWidth)
    ) u_timebase (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .en        (ctrl_q.en),
        .clr       (wr_en & sel_pre),
        .prescale  (prescale_q),
        .pwm_cnt   (pwm_cnt),
        .pwm_wrap  (pwm_wrap)
    );

    // Per-channel PWM compare: duty 0 never lights, full scale lights all but one step
    always_comb begin
        pwm_on = '0;
        for (int i = 0; i < NumLeds; i++) pwm_on[i] = (duty_q[i] > pwm_cnt);
    end

`ifdef LED_PWM_CTRL_BLINK_EN
    // Blink phase flips after HALF wraps; a BLINK write restarts the phase
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            blink_mask_q  <= '0;
            blink_half_q  <= 8'd0;
            blink_cnt_q   <= 8'd0;
            blink_phase_q <= 1'b0;
        end else if (wr_en && sel_blink) begin
            blink_mask_q  <= wr_word[BLINK_MASK_LSB +: NumLeds];
            blink_half_q  <= wr_word[BLINK_HALF_LSB +: BLINK_HALF_W];
            blink_cnt_q   <= 8'd0;
            blink_phase_q <= 1'b0;
        end else if (blink_half_q == 8'd0) begin
            blink_cnt_q   <= 8'd0;
            blink_phase_q <= 1'b0;
        end else if (pwm_wrap) begin
            if (blink_cnt_q == blink_half_q - 8'd1) begin
                blink_cnt_q   <= 8'd0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 8'd1;
            end
        end
    end

    assign blink_off = blink_phase_q ? blink_mask_q : '0;
`else
    assign blink_off = '0;
`endif

    // Output flop: disabled -> dark, else direct or PWM with blink gating
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            led_o <= '0;
        end else if (!ctrl_q.en) begin
            led_o <= '0;
        end else if (ctrl_q.mode) begin
            led_o <= pwm_on & ~blink_off;
        end else begin
            led_o <= out_q & ~blink_off;
        end
    end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl (NumLeds=4, PwmWidth=8, PrescaleReset=5).
// Register accesses are predicted by a word-level register model; LED and
// wrap behaviour by duty-cycle arithmetic over whole PWM periods.
module tb_led_pwm_ctrl;

    localparam int          NUM     = 4;
    localparam int          PW      = 8;
    localparam logic [15:0] PRE_RST = 16'd5;

    logic            clk_sys = 1'b0;
    logic            rst_sys_n = 1'b0;
    logic            req = 1'b0;
    logic            we = 1'b0;
    logic [3:0]      be = 4'd0;
    logic [31:0]     addr = 32'd0;
    logic [31:0]     wdata = 32'd0;
    logic            gnt_o;
    logic            rvalid_o;
    logic [31:0]     rdata_o;
    logic            err_o;
    logic [NUM-1:0]  led_o;
    logic            pwm_wrap_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] ctrl_m, out_m, prescale_m, blink_m;
    int          duty_m [NUM];

    always #5 clk_sys = ~clk_sys;

    led_pwm_ctrl #(
        .NumLeds       (NUM),
        .PwmWidth      (PW),
        .PrescaleReset (PRE_RST)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_sys_n  (rst_sys_n),
        .req_i      (req),
        .gnt_o      (gnt_o),
        .we_i       (we),
        .be_i       (be),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .led_o      (led_o),
        .pwm_wrap_o (pwm_wrap_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ctrl_m = 0; out_m = 0; prescale_m = 32'(PRE_RST); blink_m = 0;
        for (int i = 0; i < NUM; i++) duty_m[i] = 0;
    endtask

    // Returns {mapped, contents} for a word index
    function automatic logic [32:0] model_rd(input logic [5:0] w);
        int off;
        off = int'(w) * 4;
        if (off == 0) return {1'b1, ctrl_m};
        if (off == 4) return {1'b1, out_m};
        if (off == 8) return {1'b1, prescale_m};
`ifdef LED_PWM_CTRL_BLINK_EN
        if (off == 12) return {1'b1, blink_m};
`endif
        if (off >= 32 && off < 32 + 4 * NUM) return {1'b1, 32'(duty_m[(off - 32) / 4])};
        return 33'd0;
    endfunction

    function automatic void model_wr(input logic [5:0] w, input logic [3:0] b, input logic [31:0] d);
        logic [32:0] r;
        logic [31:0] m;
        int off;
        r = model_rd(w);
        if (!r[32]) return;
        m = r[31:0];
        for (int k = 0; k < 4; k++) if (b[k]) m[8*k +: 8] = d[8*k +: 8];
        off = int'(w) * 4;
        if (off == 0) ctrl_m = m & 32'h3;
        else if (off == 4) out_m = m & ((32'd1 << NUM) - 1);
        else if (off == 8) prescale_m = m & 32'hFFFF;
`ifdef LED_PWM_CTRL_BLINK_EN
        else if (off == 12) blink_m = m & (32'h00FF0000 | ((32'd1 << NUM) - 1));
`endif
        else duty_m[(off - 32) / 4] = int'(m & ((32'd1 << PW) - 1));
    endfunction

    // One bus transaction, checked against the model, then applied to it
    task automatic xact(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
        logic [32:0] exp;
        exp = model_rd(a[7:2]);
        @(negedge clk_sys);
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        #1 check({tag, "_gnt"}, 32'(gnt_o), 32'd1);
        @(posedge clk_sys);
        #1;
        req = 1'b0; we = 1'b0; be = 4'd0;
        check({tag, "_rvalid"}, 32'(rvalid_o), 32'd1);
        check({tag, "_err"}, 32'(err_o), 32'(!exp[32]));
        check({tag, "_rdata"}, rdata_o, (w || !exp[32]) ? 32'd0 : exp[31:0]);
        if (w) model_wr(a[7:2], b, d);
    endtask

    // Waits for a wrap pulse; n = samples taken (bound+1 when no pulse arrives)
    task automatic wait_wrap(input int bound, output int n);
        n = 0;
        while (n <= bound) begin
            @(posedge clk_sys);
            #1;
            n++;
            if (pwm_wrap_o) return;
        end
    endtask

    initial begin
        int offs [12] = '{0, 4, 8, 12, 16, 28, 32, 36, 40, 44, 48, 60};
        int hi [NUM];
        int wraps, n;
        logic [31:0] r;
        logic ok;

        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_led", 32'(led_o), 32'd0);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_wrap", 32'(pwm_wrap_o), 32'd0);
        @(negedge clk_sys);
        rst_sys_n = 1'b1;

        xact(1'b0, 4'hF, 32'h08, 32'd0, "rd_prescale_rst");
        xact(1'b1, 4'hF, 32'h00, 32'h1, "wr_ctrl_en");
        xact(1'b1, 4'hF, 32'h04, 32'hA, "wr_out");
        check("led_before_out", 32'(led_o), 32'h0);
        @(posedge clk_sys);
        #1 check("led_direct", 32'(led_o), 32'hA);
        xact(1'b0, 4'hF, 32'h04, 32'd0, "rd_out");
        xact(1'b1, 4'h0, 32'h04, 32'hFF, "wr_out_be0");
        xact(1'b0, 4'hF, 32'h04, 32'd0, "rd_out_kept");
        xact(1'b0, 4'hF, 32'h10, 32'd0, "rd_unmapped");
        xact(1'b0, 4'hF, 32'h30, 32'd0, "rd_duty4");
        xact(1'b1, 4'hF, 32'h10, 32'hFFFF_FFFF, "wr_unmapped");
        xact(1'b0, 4'hF, 32'h0C, 32'd0, "rd_blink");
`ifdef LED_PWM_CTRL_BLINK_EN
        xact(1'b1, 4'hF, 32'h0C, 32'h0002_0001, "wr_blink");
        xact(1'b0, 4'hF, 32'h0C, 32'd0, "rd_blink_back");
`endif

        // Randomized register traffic against the model
        for (int t = 0; t < 60; t++) begin
            r = $urandom();
            addr = (r & 32'hFFFF_FF00) | 32'(offs[$urandom_range(0, 11)]) | ($urandom() & 32'h3);
            xact(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), addr, $urandom(), "rand");
        end

        // PWM with PRESCALE=0: duty cycles and 256-cycle wrap period
`ifdef LED_PWM_CTRL_BLINK_EN
        xact(1'b1, 4'hF, 32'h0C, 32'd0, "wr_blink_off");
`endif
        xact(1'b1, 4'hF, 32'h08, 32'd0, "wr_pre0");
        xact(1'b1, 4'hF, 32'h20, 32'd64, "wr_duty0");
        xact(1'b1, 4'hF, 32'h24, 32'd0, "wr_duty1");
        xact(1'b1, 4'hF, 32'h28, $urandom_range(1, 254), "wr_duty2");
        xact(1'b1, 4'hF, 32'h2C, 32'd255, "wr_duty3");
        xact(1'b1, 4'hF, 32'h00, 32'h3, "wr_ctrl_pwm");
        wait_wrap(600, n);
        check("wrap_seen_p0", 32'(n <= 600), 32'd1);
        for (int i = 0; i < NUM; i++) hi[i] = 0;
        wraps = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk_sys);
            #1;
            for (int i = 0; i < NUM; i++) hi[i] += int'(led_o[i]);
            wraps += int'(pwm_wrap_o);
        end
        for (int i = 0; i < NUM; i++) check($sformatf("duty_ch%0d", i), 32'(hi[i]), 32'(duty_m[i]));
        check("wraps_256", 32'(wraps), 32'd1);
        check("wrap_at_end", 32'(pwm_wrap_o), 32'd1);

        // PRESCALE=3 written mid-period restarts the timebase
        repeat ($urandom_range(20, 200)) @(posedge clk_sys);
        xact(1'b1, 4'hF, 32'h08, 32'd3, "wr_pre3");
        wait_wrap(1100, n);
        check("first_wrap_p3", 32'(n), 32'd1024);
        hi[0] = 0;
        wraps = 0;
        for (int k = 0; k < 1024; k++) begin
            @(posedge clk_sys);
            #1;
            hi[0] += int'(led_o[0]);
            wraps += int'(pwm_wrap_o);
        end
        check("duty_ch0_p3", 32'(hi[0]), 32'(duty_m[0] * 4));
        check("wraps_1024", 32'(wraps), 32'd1);

`ifdef LED_PWM_CTRL_BLINK_EN
        // Blink: direct OUT=1, mask=1, HALF=2 -> toggles every 512 cycles
        xact(1'b1, 4'hF, 32'h08, 32'd0, "wr_pre0_b");
        xact(1'b1, 4'hF, 32'h04, 32'h1, "wr_out_b");
        xact(1'b1, 4'hF, 32'h00, 32'h1, "wr_ctrl_b");
        xact(1'b1, 4'hF, 32'h0C, 32'h0002_0001, "wr_blink_b");
        n = 0;
        while (led_o[0] !== 1'b0 && n < 1200) begin @(posedge clk_sys); #1; n++; end
        check("blink_off_seen", 32'(n < 1200), 32'd1);
        n = 0;
        while (led_o[0] !== 1'b1 && n < 1200) begin @(posedge clk_sys); #1; n++; end
        check("blink_half_period", 32'(n), 32'd512);
        xact(1'b1, 4'hF, 32'h0C, 32'd0, "wr_blink_clr");
`endif

        // EN=0 darkens LEDs one cycle after CTRL updates and stops the timebase
        xact(1'b1, 4'hF, 32'h08, 32'd0, "wr_pre0_d");
        xact(1'b1, 4'hF, 32'h00, 32'h0, "wr_ctrl_dis");
        @(posedge clk_sys);
        #1 check("led_disabled", 32'(led_o), 32'd0);
        wraps = 0;
        ok = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk_sys);
            #1;
            wraps += int'(pwm_wrap_o);
            if (led_o !== '0) ok = 1'b0;
        end
        check("no_wrap_disabled", 32'(wraps), 32'd0);
        check("led_dark_disabled", 32'(ok), 32'd1);

        // Reset while a response is pending drops it
        @(negedge clk_sys);
        req = 1'b1; we = 1'b0; addr = 32'h04;
        @(posedge clk_sys);
        #1;
        req = 1'b0;
        check("pending_rvalid", 32'(rvalid_o), 32'd1);
        rst_sys_n = 1'b0;
        #1 check("rvalid_dropped", 32'(rvalid_o), 32'd0);
        model_reset();
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
        ok = 1'b1;
        repeat (3) begin
            @(posedge clk_sys);
            #1;
            if (rvalid_o !== 1'b0) ok = 1'b0;
        end
        check("no_resp_after_rst", 32'(ok), 32'd1);
        xact(1'b0, 4'hF, 32'h08, 32'd0, "rd_prescale_rst2");
        xact(1'b0, 4'hF, 32'h20, 32'd0, "rd_duty0_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
